// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war round controller.
//   tow_state_t  : FSM state encoding
//   TICK_CNT_W   : width of the round/countdown tick counter
//   centre_pos() : rope centre position for a given end position
package tow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_ROUND     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SCORE     = 3'd4,
        ST_CLEAR     = 3'd5,
        ST_GAMEOVER  = 3'd6
    } tow_state_t;

    localparam int TICK_CNT_W = 8;

    function automatic logic [3:0] centre_pos(input int pos_max);
        return 4'(pos_max / 2);
    endfunction

endpackage

// File: rtl/tow_round_ctrl_tick_timer.sv
// tick_timer: 8-bit up-counter of tick strobes with synchronous clear and a
// terminal-count compare.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over counting)
//   en       : counting enabled in the current state
//   tick     : time-base strobe
//   target   : number of ticks that ends the interval (>= 1)
//   done     : the tick arriving this cycle is the target-th one
module tick_timer
    import tow_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  tick,
    input  logic [TICK_CNT_W-1:0] target,
    output logic                  done
);

    logic [TICK_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && tick) begin
            count <= count + 1'b1;
        end
    end

    // Compare against target-1 so the interval ends on the edge that
    // samples the final tick, not one tick later.
    assign done = en && tick && (count == target - 1'b1);

endmodule

// File: rtl/tow_round_ctrl.sv
// tow_round_ctrl: sequences tug-of-war speed rounds and moves the rope.
//   clk, rst      : clock, async active-high reset
//   start         : one-cycle start/restart pulse (honoured in IDLE/GAMEOVER)
//   tick          : one-cycle time-base strobe
//   speed_right   : right side pushed more in the last round
//   speed_tie     : both sides pushed equally (priority over speed_right)
//   speedRound    : push counters enabled
//   speedExit     : one-cycle clear of the push counters
//   rope_pos      : rope position 0..POS_MAX
//   countdown     : "get ready" phase
//   game_over     : a side has pulled the rope to its end
//   winner_right  : valid with game_over, 1 = right side won
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | waiting for start
// COUNTDOWN  | counting COUNTDOWN_TICKS ticks before a round
// ROUND      | speedRound high for ROUND_TICKS ticks
// SETTLE     | 2 cycles for the push counter compare to settle
// SCORE      | 1 cycle, sample result and move the rope
// CLEAR      | 1 cycle, speedExit high, check for an end position
// GAMEOVER   | result held until start
module tow_round_ctrl
    import tow_pkg::*;
#(
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 200,
    parameter int POS_MAX         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic       speed_right,
    input  logic       speed_tie,
    output logic       speedRound,
    output logic       speedExit,
    output logic [3:0] rope_pos,
    output logic       countdown,
    output logic       game_over,
    output logic       winner_right
);

    localparam logic [3:0] POS_END = 4'(POS_MAX);
    localparam logic [3:0] POS_MID = centre_pos(POS_MAX);

    tow_state_t            state, state_nxt;
    logic                  settle_2nd, settle_2nd_nxt;
    logic [3:0]            rope_nxt;
    logic                  winner_nxt;
    logic                  timing, timer_clr, timer_done;
    logic [TICK_CNT_W-1:0] timer_target;

    // The counter only runs in the two timed states; it sits at zero
    // elsewhere, so a tick on the first cycle of a timed state counts.
    assign timing       = (state == ST_COUNTDOWN) || (state == ST_ROUND);
    assign timer_target = (state == ST_ROUND) ? TICK_CNT_W'(ROUND_TICKS)
                                              : TICK_CNT_W'(COUNTDOWN_TICKS);
    assign timer_clr    = !timing || timer_done;

    tick_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timing),
        .tick   (tick),
        .target (timer_target),
        .done   (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            settle_2nd   <= 1'b0;
            rope_pos     <= POS_MID;
            winner_right <= 1'b0;
        end else begin
            state        <= state_nxt;
            settle_2nd   <= settle_2nd_nxt;
            rope_pos     <= rope_nxt;
            winner_right <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_2nd_nxt = 1'b0;
        rope_nxt       = rope_pos;
        winner_nxt     = winner_right;

        unique case (state)
            ST_IDLE, ST_GAMEOVER: begin
                if (start) begin
                    state_nxt  = ST_COUNTDOWN;
                    rope_nxt   = POS_MID;
                    winner_nxt = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (timer_done) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                if (timer_done) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                settle_2nd_nxt = !settle_2nd;
                if (settle_2nd) state_nxt = ST_SCORE;
            end
            ST_SCORE: begin
                state_nxt = ST_CLEAR;
                if (speed_tie) begin
                    rope_nxt = rope_pos;
                end else if (speed_right) begin
                    if (rope_pos != POS_END) rope_nxt = rope_pos + 4'd1;
                end else begin
                    if (rope_pos != 4'd0) rope_nxt = rope_pos - 4'd1;
                end
            end
            ST_CLEAR: begin
                if ((rope_pos == 4'd0) || (rope_pos == POS_END)) begin
                    state_nxt  = ST_GAMEOVER;
                    winner_nxt = (rope_pos == POS_END);
                end else begin
                    state_nxt = ST_COUNTDOWN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign speedRound = (state == ST_ROUND);
    assign speedExit  = (state == ST_CLEAR);
    assign countdown  = (state == ST_COUNTDOWN);
    assign game_over  = (state == ST_GAMEOVER);

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Self-checking bench for tow_round_ctrl: randomized tick/start/result
// stimulus checked against a round-level model of rope position and timing.
module tb_tow_round_ctrl;

    localparam int CD     = 3;
    localparam int RT     = 200;
    localparam int PM     = 8;
    localparam int CENTRE = PM / 2;

    logic clk = 1'b0;
    logic rst;
    logic start, tick, speed_right, speed_tie;
    logic speedRound, speedExit, countdown, game_over, winner_right;
    logic [3:0] rope_pos;

    logic start_b, tick_b;
    logic sr_b, se_b, cd_b, go_b, wr_b;
    logic [3:0] rp_b;

    int checks   = 0;
    int failures = 0;
    int exp_pos;

    always #5 clk = ~clk;

    tow_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .speed_right(speed_right), .speed_tie(speed_tie),
        .speedRound(speedRound), .speedExit(speedExit), .rope_pos(rope_pos),
        .countdown(countdown), .game_over(game_over), .winner_right(winner_right)
    );

    tow_round_ctrl #(.COUNTDOWN_TICKS(CD), .ROUND_TICKS(1), .POS_MAX(PM)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tick(tick_b),
        .speed_right(1'b0), .speed_tie(1'b1),
        .speedRound(sr_b), .speedExit(se_b), .rope_pos(rp_b),
        .countdown(cd_b), .game_over(go_b), .winner_right(wr_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic coin(input int num, input int den);
        return ($urandom_range(den - 1, 0) < num);
    endfunction

    // Called one cycle after COUNTDOWN was entered. Plays one full round with
    // the given push result and updates the rope model.
    task automatic play_round(input logic r, input logic t, input bit first_tick,
                              output bit over);
        int n;
        bit first;
        n = 0;
        first = 1'b1;
        while (n < CD) begin
            check("cd_high", countdown, 1);
            check("sr_low_in_cd", speedRound, 0);
            tick  = (first && first_tick) ? 1'b1 : coin(2, 3);
            start = coin(1, 4);
            first = 1'b0;
            step();
            if (tick) n++;
        end
        n = 0;
        while (n < RT) begin
            check("sr_high", speedRound, 1);
            check("cd_low_in_round", countdown, 0);
            check("sr_se_exclusive", speedRound & speedExit, 0);
            tick  = coin(2, 3);
            start = coin(1, 4);
            step();
            if (tick) n++;
        end
        speed_right = r;
        speed_tie   = t;
        check("sr_fall", speedRound, 0);
        check("se_settle1", speedExit, 0);
        tick = coin(1, 2); start = coin(1, 2);
        step();
        check("sr_settle2", speedRound, 0);
        check("se_settle2", speedExit, 0);
        tick = coin(1, 2); start = coin(1, 2);
        step();
        check("se_score", speedExit, 0);
        check("pos_before_score", rope_pos, exp_pos);
        tick = coin(1, 2); start = coin(1, 2);
        step();
        if (t)      exp_pos = exp_pos;
        else if (r) exp_pos = (exp_pos + 1 > PM) ? PM : exp_pos + 1;
        else        exp_pos = (exp_pos - 1 < 0) ? 0 : exp_pos - 1;
        check("se_clear", speedExit, 1);
        check("sr_clear", speedRound, 0);
        check("pos_after_score", rope_pos, exp_pos);
        tick = coin(1, 2); start = coin(1, 2);
        step();
        start = 1'b0;
        tick  = 1'b0;
        over  = (exp_pos == 0) || (exp_pos == PM);
        check("se_one_cycle", speedExit, 0);
        check("game_over", game_over, int'(over));
        check("cd_next_round", countdown, int'(!over));
        if (over) check("winner_right", winner_right, int'(exp_pos == PM));
    endtask

    initial begin
        bit over;
        int n, rounds, period;
        logic r, t;

        rst = 1'b1; start = 1'b0; tick = 1'b0;
        speed_right = 1'b0; speed_tie = 1'b0;
        start_b = 1'b0; tick_b = 1'b0;
        #12;
        check("rst_sr", speedRound, 0);
        check("rst_se", speedExit, 0);
        check("rst_cd", countdown, 0);
        check("rst_go", game_over, 0);
        check("rst_wr", winner_right, 0);
        check("rst_pos", rope_pos, CENTRE);
        check("rst_b_pos", rp_b, CENTRE);
        step();
        rst = 1'b0;

        repeat (10) begin
            tick = coin(1, 2);
            step();
            check("idle_cd", countdown, 0);
            check("idle_sr", speedRound, 0);
        end
        tick = 1'b0;

        // First game: directed results, then right-biased random rounds.
        exp_pos = CENTRE;
        start = 1'b1; step(); start = 1'b0;
        check("start_pos", rope_pos, CENTRE);
        play_round(1'b1, 1'b0, 1'b1, over);
        play_round(1'b1, 1'b1, 1'b0, over);
        play_round(1'b0, 1'b1, 1'b0, over);
        play_round(1'b0, 1'b0, 1'b0, over);
        rounds = 0;
        while (!over && rounds < 60) begin
            r = coin(3, 4);
            t = coin(1, 8);
            play_round(r, t, 1'b0, over);
            rounds++;
        end
        check("game1_over", game_over, int'(over));

        repeat (20) begin
            tick = coin(1, 2);
            step();
            check("hold_go", game_over, int'(over));
            check("hold_pos", rope_pos, exp_pos);
            check("hold_sr", speedRound, 0);
        end
        tick = 1'b0;

        // Second game: left wins every round from the centre.
        exp_pos = CENTRE;
        start = 1'b1; step(); start = 1'b0;
        check("restart_pos", rope_pos, CENTRE);
        check("restart_cd", countdown, 1);
        check("restart_wr", winner_right, 0);
        rounds = 0;
        over = 1'b0;
        while (!over && rounds < 10) begin
            play_round(1'b0, 1'b0, 1'b0, over);
            rounds++;
        end
        check("left_pos", rope_pos, 0);
        check("left_go", game_over, 1);
        check("left_wr", winner_right, 0);
        repeat (20) begin
            tick = 1'b1;
            step();
            check("left_no_round", speedRound, 0);
            check("left_hold_go", game_over, 1);
        end
        tick = 1'b0;

        // Third game: reset in the middle of a round.
        exp_pos = CENTRE;
        start = 1'b1; step(); start = 1'b0;
        check("restart2_pos", rope_pos, CENTRE);
        check("restart2_cd", countdown, 1);
        n = 0;
        while (n < CD) begin tick = coin(2, 3); step(); if (tick) n++; end
        n = 0;
        while (n < 100) begin
            check("pre_rst_sr", speedRound, 1);
            tick = coin(2, 3);
            step();
            if (tick) n++;
        end
        tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_sr", speedRound, 0);
        check("async_rst_se", speedExit, 0);
        check("async_rst_cd", countdown, 0);
        check("async_rst_go", game_over, 0);
        check("async_rst_pos", rope_pos, CENTRE);
        step();
        rst = 1'b0;
        repeat (10) begin
            tick = 1'b1;
            step();
            check("post_rst_se", speedExit, 0);
            check("post_rst_sr", speedRound, 0);
            check("post_rst_cd", countdown, 0);
            check("post_rst_pos", rope_pos, CENTRE);
        end
        tick = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check("post_rst_idle", countdown, 1);

        // ROUND_TICKS = 1 with tick held high: one-cycle rounds.
        // Round period = countdown + round + 2 settle + score + clear.
        period = CD + 1 + 2 + 1 + 1;
        start_b = 1'b1; step(); start_b = 1'b0;
        tick_b = 1'b1;
        for (int k = 0; k < 3 * period; k++) begin
            check("b_sr", sr_b, int'((k % period) == CD));
            check("b_se", se_b, int'((k % period) == period - 1));
            check("b_cd", cd_b, int'((k % period) < CD));
            check("b_pos", rp_b, CENTRE);
            step();
        end
        tick_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
